// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
// Sequences one external memory bus cycle per core request. The 16-bit
// address leaves on the 8-bit address pins high byte first, then low byte.
// A DATA phase follows in which the data pins are driven for writes or
// sampled for reads. An external ready line can stretch the DATA phase up to
// WAIT_MAX cycles before the cycle is aborted. Completion is reported with a
// one-cycle ack pulse. err marks a cycle that was aborted by timeout.
//
// Every output is either a flop or a pure decode of the state register, so
// no input has a combinational path to a pin.
module bus_cycle_controller #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rdy,
    input  logic [7:0]  bus_data_in,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [7:0]  bus_addr_out,
    output logic [7:0]  bus_data_out,
    output logic [7:0]  bus_data_oe,
    output logic [1:0]  bus_phase
);

    // The state encoding doubles as the bus_phase value seen by the board.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR_HI = 2'd1,
        ST_ADDR_LO = 2'd2,
        ST_DATA    = 2'd3
    } state_t;

    // Timeout compare value. The wait counter is 8 bits wide, which covers
    // the legal WAIT_MAX range of 1..255.
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t      state_q,    state_d;
    logic [15:0] addr_q,     addr_d;
    logic        rw_q,       rw_d;
    logic [7:0]  wdata_q,    wdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        ack_q,      ack_d;
    logic        err_q,      err_d;
    logic [7:0]  rdata_q,    rdata_d;
    logic [7:0]  addr_out_q, addr_out_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  data_oe_q,  data_oe_d;

    // Next-state and next-output computation for the whole bus cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;

        case (state_q)
            ST_IDLE: begin
                data_oe_d  = 8'h00;
                data_out_d = 8'h00;
                if (req) begin
                    // Capture the request. From here until ack the cycle
                    // runs only on these latched copies.
                    addr_d     = addr;
                    rw_d       = rw;
                    wdata_d    = wdata;
                    addr_out_d = addr[15:8];
                    state_d    = ST_ADDR_HI;
                end else begin
                    addr_out_d = 8'h00;
                end
            end

            ST_ADDR_HI: begin
                addr_out_d = addr_q[7:0];
                state_d    = ST_ADDR_LO;
            end

            ST_ADDR_LO: begin
                // The low byte stays on the pins through DATA. Drive the bus
                // only once DATA begins.
                addr_out_d = addr_q[7:0];
                wait_cnt_d = 8'd0;
                state_d    = ST_DATA;
                if (rw_q) begin
                    data_oe_d  = 8'hFF;
                    data_out_d = wdata_q;
                end else begin
                    data_oe_d  = 8'h00;
                    data_out_d = 8'h00;
                end
            end

            ST_DATA: begin
                if (rdy) begin
                    if (!rw_q) begin
                        rdata_d = bus_data_in;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d      = 1'b1;
                    err_d      = 1'b0;
                    addr_out_d = 8'h00;
                    data_oe_d  = 8'h00;
                    data_out_d = 8'h00;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    // The wait budget is used up, so abort. rdata keeps the
                    // last good byte.
                    ack_d      = 1'b1;
                    err_d      = 1'b1;
                    addr_out_d = 8'h00;
                    data_oe_d  = 8'h00;
                    data_out_d = 8'h00;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                addr_out_d = 8'h00;
                data_oe_d  = 8'h00;
                data_out_d = 8'h00;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered-output flops. Reset is asynchronous, so the bus
    // is released immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 16'h0000;
            rw_q       <= 1'b0;
            wdata_q    <= 8'h00;
            wait_cnt_q <= 8'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            addr_out_q <= 8'h00;
            data_out_q <= 8'h00;
            data_oe_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign ack          = ack_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign bus_phase    = state_q;
    assign bus_addr_out = addr_out_q;
    assign bus_data_out = data_out_q;
    assign bus_data_oe  = data_oe_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller. Outputs are sampled 1 ns after
// each rising edge and compared against hand-computed values.
module tb_bus_cycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        rdy = 1'b0;
    logic [7:0]  bus_data_in = 8'h00;
    logic        ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic [7:0]  bus_addr_out;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_oe;
    logic [1:0]  bus_phase;

    int checks = 0;
    int errors = 0;
    int early_ack;

    bus_cycle_controller #(.WAIT_MAX(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .rw           (rw),
        .addr         (addr),
        .wdata        (wdata),
        .rdy          (rdy),
        .bus_data_in  (bus_data_in),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .busy         (busy),
        .bus_addr_out (bus_addr_out),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .bus_phase    (bus_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks every output against the values expected while the block idles.
    task automatic chk_idle(input string tag, input logic [7:0] exp_rdata);
        chk({tag, "_phase"}, {14'd0, bus_phase}, 16'd0);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_addr"}, {8'd0, bus_addr_out}, 16'h0000);
        chk({tag, "_dout"}, {8'd0, bus_data_out}, 16'h0000);
        chk({tag, "_oe"}, {8'd0, bus_data_oe}, 16'h0000);
        chk({tag, "_rdata"}, {8'd0, rdata}, {8'd0, exp_rdata});
    endtask

    initial begin
        // Reset state
        #2;
        chk_idle("rst", 8'h00);
        chk("rst_ack", {15'd0, ack}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);

        // Read, no wait
        #1 rst_n = 1'b1;
        req = 1'b1; rw = 1'b0; addr = 16'hABCD; rdy = 1'b1; bus_data_in = 8'h5A;
        step();
        req = 1'b0;
        chk("rd_ph1", {14'd0, bus_phase}, 16'd1);
        chk("rd_a1", {8'd0, bus_addr_out}, 16'h00AB);
        chk("rd_busy", {15'd0, busy}, 16'd1);
        chk("rd_oe1", {8'd0, bus_data_oe}, 16'h0000);
        step();
        chk("rd_ph2", {14'd0, bus_phase}, 16'd2);
        chk("rd_a2", {8'd0, bus_addr_out}, 16'h00CD);
        chk("rd_oe2", {8'd0, bus_data_oe}, 16'h0000);
        step();
        chk("rd_ph3", {14'd0, bus_phase}, 16'd3);
        chk("rd_a3", {8'd0, bus_addr_out}, 16'h00CD);
        chk("rd_oe3", {8'd0, bus_data_oe}, 16'h0000);
        chk("rd_noack", {15'd0, ack}, 16'd0);
        step();
        chk("rd_ack", {15'd0, ack}, 16'd1);
        chk("rd_err", {15'd0, err}, 16'd0);
        chk_idle("rd_done", 8'h5A);
        step();
        chk("rd_ackpulse", {15'd0, ack}, 16'd0);

        // Write with two wait cycles
        req = 1'b1; rw = 1'b1; addr = 16'h1234; wdata = 8'hC3; rdy = 1'b0;
        bus_data_in = 8'hEE;
        step();
        req = 1'b0; wdata = 8'h00; rw = 1'b0;
        chk("wr_a1", {8'd0, bus_addr_out}, 16'h0012);
        chk("wr_oe1", {8'd0, bus_data_oe}, 16'h0000);
        step();
        chk("wr_a2", {8'd0, bus_addr_out}, 16'h0034);
        chk("wr_oe2", {8'd0, bus_data_oe}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) rdy = 1'b1;
            chk("wr_dph", {14'd0, bus_phase}, 16'd3);
            chk("wr_doe", {8'd0, bus_data_oe}, 16'h00FF);
            chk("wr_dout", {8'd0, bus_data_out}, 16'h00C3);
            chk("wr_dnoack", {15'd0, ack}, 16'd0);
        end
        step();
        rdy = 1'b0;
        chk("wr_ack", {15'd0, ack}, 16'd1);
        chk("wr_err", {15'd0, err}, 16'd0);
        chk_idle("wr_done", 8'h5A);

        // Write timeout, rdy held low, WAIT_MAX = 15 gives ack at cycle 18
        step();
        req = 1'b1; rw = 1'b1; addr = 16'h0F0F; wdata = 8'hE7; bus_data_in = 8'h77;
        step();
        req = 1'b0;
        early_ack = 0;
        for (int i = 1; i < 18; i++) begin
            step();
            if (ack !== 1'b0) early_ack++;
        end
        chk("to_noearly", early_ack[15:0], 16'd0);
        chk("to_oe_data", {8'd0, bus_data_oe}, 16'h00FF);
        step();
        chk("to_ack", {15'd0, ack}, 16'd1);
        chk("to_err", {15'd0, err}, 16'd1);
        chk_idle("to_done", 8'h5A);
        step();
        chk("to_ackpulse", {15'd0, ack}, 16'd0);
        chk("to_errclr", {15'd0, err}, 16'd0);

        // Back-to-back with held req and mid-cycle addr change
        req = 1'b1; rw = 1'b0; addr = 16'h1111; rdy = 1'b1; bus_data_in = 8'hA1;
        step();
        chk("bb_ph1", {14'd0, bus_phase}, 16'd1);
        chk("bb_a1", {8'd0, bus_addr_out}, 16'h0011);
        addr = 16'h2222;
        step();
        chk("bb_a2", {8'd0, bus_addr_out}, 16'h0011);
        step();
        chk("bb_a3", {8'd0, bus_addr_out}, 16'h0011);
        step();
        chk("bb_ack1", {15'd0, ack}, 16'd1);
        chk("bb_rd1", {8'd0, rdata}, 16'h00A1);
        chk("bb_ph0", {14'd0, bus_phase}, 16'd0);
        bus_data_in = 8'hB2;
        step();
        chk("bb_restart", {14'd0, bus_phase}, 16'd1);
        chk("bb_b1", {8'd0, bus_addr_out}, 16'h0022);
        req = 1'b0; addr = 16'h3333;
        step();
        chk("bb_b2", {8'd0, bus_addr_out}, 16'h0022);
        step();
        chk("bb_b3", {8'd0, bus_addr_out}, 16'h0022);
        step();
        chk("bb_ack2", {15'd0, ack}, 16'd1);
        chk("bb_rd2", {8'd0, rdata}, 16'h00B2);
        step();

        // Asynchronous reset during a write DATA phase
        req = 1'b1; rw = 1'b1; addr = 16'h5555; wdata = 8'h99; rdy = 1'b0;
        step();
        req = 1'b0;
        step();
        step();
        chk("rm_oe", {8'd0, bus_data_oe}, 16'h00FF);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("rm_async", 8'h00);
        chk("rm_ack", {15'd0, ack}, 16'd0);
        step();
        step();
        chk("rm_noack", {15'd0, ack}, 16'd0);
        rst_n = 1'b1;
        req = 1'b1; rw = 1'b0; addr = 16'h6666; rdy = 1'b1; bus_data_in = 8'h42;
        step();
        req = 1'b0;
        chk("rm_a1", {8'd0, bus_addr_out}, 16'h0066);
        step();
        step();
        step();
        chk("rm_ack2", {15'd0, ack}, 16'd1);
        chk("rm_err2", {15'd0, err}, 16'd0);
        chk("rm_rdata", {8'd0, rdata}, 16'h0042);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequences external memory bus cycles for the 6502 core on the TinyTapeout pin budget. It time-multiplexes a 16-bit CPU address onto the 8-bit `uo_out` address pins, high byte first, then low byte. It drives or tri-states the 8-bit `uio` data pins, honours an external ready line with a bounded wait, and returns read data to the core through a req/ack handshake. It sits between the core's address/data latches and the top-level pin assignments, and replaces free-running address alternation with explicit, requester-driven cycles.

## Interface
- `WAIT_MAX`, default 15: maximum consecutive rdy-low cycles in DATA before the cycle aborts; legal range 1..255.

- `clk` input 1: single system clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: cycle request from the core; sampled only in IDLE.
- `rw` input 1: 0 = read, 1 = write; latched with `req`.
- `addr` input 16: cycle address; latched with `req`.
- `wdata` input 8: write data; latched with `req`.
- `rdy` input 1: external memory ready; sampled only in DATA.
- `bus_data_in` input 8: from `uio_in`.
- `ack` output 1: one-cycle completion pulse.
- `err` output 1: valid with `ack`; 1 = cycle aborted by timeout.
- `rdata` output 8: last successfully read byte; holds until the next successful read.
- `busy` output 1: high whenever the state is not IDLE.
- `bus_addr_out` output 8: to `uo_out`.
- `bus_data_out` output 8: to `uio_out`.
- `bus_data_oe` output 8: to `uio_oe`; either 8'h00 or 8'hFF.
- `bus_phase` output 2: 0 = IDLE, 1 = ADDR_HI, 2 = ADDR_LO, 3 = DATA; lets the top level or board logic latch the address bytes.

## Operation
- States are IDLE, ADDR_HI, ADDR_LO and DATA, encoded as `bus_phase`.
- IDLE:
  - Outputs: `bus_addr_out` = 0, `bus_data_oe` = 0, `bus_data_out` = 0.
  - If `req` = 1: latch `addr`, `rw` and `wdata`, then go to ADDR_HI.
- ADDR_HI: `bus_addr_out` = addr[15:8] for exactly one cycle, then go to ADDR_LO.
- ADDR_LO: `bus_addr_out` = addr[7:0] for exactly one cycle, then go to DATA. `bus_data_oe` stays 0.
- DATA:
  - `bus_addr_out` holds addr[7:0].
  - Write: `bus_data_out` = latched wdata and `bus_data_oe` = 8'hFF for every DATA cycle, including wait cycles.
  - Read: `bus_data_oe` = 0.
- DATA completion, when `rdy` = 1 at the clock edge:
  - Read: `rdata` ← `bus_data_in`.
  - Next state IDLE; `ack` = 1 and `err` = 0 for the following cycle.
- DATA wait, when `rdy` = 0: the 8-bit wait counter increments.
- DATA timeout: when the counter reaches `WAIT_MAX`, go to IDLE with `ack` = 1 and `err` = 1. `rdata` is unchanged.
- The wait counter clears on entry to DATA.
- `req` is ignored while `busy` = 1. A request is never queued; the core re-asserts `req` after `ack`.
- `req` = 1 in the same cycle that `ack` = 1 (state IDLE) is accepted, so back-to-back cycles are legal.
- Latched `addr`, `rw` and `wdata` are stable for the whole cycle. Input changes after acceptance have no effect.
- `rdy` is ignored outside DATA.

## Timing
- Reset (asynchronous, any state, mid-cycle included):
  - State = IDLE; the wait counter and latched addr/wdata/rw clear.
  - `ack`, `err`, `busy`, `rdata`, `bus_addr_out`, `bus_data_out`, `bus_data_oe` and `bus_phase` all = 0.
  - A cycle interrupted by reset produces no `ack`.
- Latency, with `req` sampled at edge E0:
  - ADDR_HI occupies cycle E0–E1, ADDR_LO E1–E2, DATA E2–E3.
  - `ack` is high in cycle E3–E4.
  - Minimum request-to-ack is 3 cycles, plus one cycle per rdy-low wait cycle.
- Timeout: `ack`/`err` appear 3 + `WAIT_MAX` cycles after acceptance.
- Throughput: a new request is accepted on the edge where `ack` is high, so one bus cycle completes every 4 clocks.
- `bus_data_oe` drops to 0 on the edge leaving DATA. The bus is never driven in IDLE, ADDR_HI or ADDR_LO, which gives a write-to-read turnaround of at least 3 cycles.
- All outputs are registered or decoded from state only. No input reaches an output combinationally.

## Test plan
- Read, no wait: reset, then `req` = 1, `rw` = 0, `addr` = 16'hABCD, `rdy` = 1, and `bus_data_in` = 8'h5A in DATA.
  - Expected: `bus_phase` 1/2/3 with `bus_addr_out` AB/CD/CD.
  - `ack` = 1, `err` = 0 at cycle 3; `rdata` = 8'h5A; `bus_data_oe` = 0 throughout.
- Write with wait: `rw` = 1, `addr` = 16'h1234, `wdata` = 8'hC3, `rdy` low for 2 DATA cycles.
  - Expected: `bus_data_oe` = 8'hFF and `bus_data_out` = 8'hC3 for 3 DATA cycles; `ack` at cycle 5.
  - `rdata` is unchanged.
- Timeout with `WAIT_MAX` = 15 and `rdy` held 0.
  - Expected: `ack` = 1, `err` = 1 at cycle 18; `rdata` is unchanged.
  - `bus_data_oe` = 0 the cycle after leaving DATA.
- Back-to-back and ignored request: hold `req` = 1 continuously with two different addresses, changing `addr` mid-cycle.
  - Expected: cycles start exactly every 4 clocks.
  - The mid-cycle `addr` change does not alter `bus_addr_out`.
- Reset mid-operation: assert `rst_n` = 0 during a write DATA cycle.
  - Expected: all outputs go to 0 immediately, without waiting for a clock edge.
  - No `ack` is produced; a fresh read after release completes normally.
